serial_sample_framer: RTL and testbench
=======================================

# serial_sample_framer

Downstream consumer of the double-buffered serial bit stream: it takes one conditioned bit per enabled clock, hunts for a fixed sync word, and then assembles the MSB-first data bits that follow into parallel samples for the symmetric FIR input. A flywheel state machine keeps lock through isolated sync errors and drops back to hunting after repeated misses. Each assembled sample is presented with a one-cycle valid strobe.

## Interface
- DATA_W, 16: bits per sample; range 2..32
- SYNC_W, 8: sync word length in bits; range 2..16
- SYNC_WORD, 8'hA5: sync pattern, MSB first on the wire
- MISS_LIMIT, 3: consecutive bad sync words that cause loss of lock; range 1..15
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  serial data bit from the double buffer
- bit_en  input  1  bit_in valid this cycle; cycles with bit_en=0 are ignored entirely
- sample_out  output  DATA_W  last assembled sample, MSB = first received data bit
- sample_valid  output  1  one-cycle pulse, sample_out updated this cycle
- locked  output  1  high while framer is in DATA or CHECK
- sync_err  output  1  one-cycle pulse on a mismatching sync word while locked

## Operation
- Reset: state HUNT; shift registers, bit counter, fill counter, and miss counter cleared; sample_out=0, sample_valid=0, locked=0, sync_err=0.
- Only cycles with bit_en=1 shift, count, or compare. Outputs are still registered every cycle: sample_valid and sync_err are 0 on any cycle not produced by an enabled last bit.
- HUNT: shift bit_in into the SYNC_W-bit sync register. The fill counter saturates at SYNC_W. A match is {sync_sr[SYNC_W-2:0], bit_in} == SYNC_WORD with the fill counter already ≥ SYNC_W-1, so a match needs SYNC_W real bits and never hits on reset zeros. On a match: go to DATA, bit counter=0, miss counter=0, locked=1.
- DATA: shift DATA_W enabled bits into the data register. On the DATA_W-th bit: sample_out <= {data_sr[DATA_W-2:0], bit_in}, sample_valid=1, then go to CHECK with bit counter=0.
- CHECK: collect SYNC_W enabled bits, then compare on the last bit.
  - Match: miss counter=0, go to DATA.
  - Mismatch: sync_err=1 and miss counter+1. If the new count equals MISS_LIMIT: go to HUNT, locked=0, fill counter=0, miss counter=0. Otherwise go to DATA (flywheel), and the following data bits are still assembled and output.
- After loss of lock, HUNT starts with an empty sync register. Bits from the failed sync word are not reused.
- sample_out holds its value between strobes and is never cleared except by rst.
- rst has priority over everything. Asserting it mid-frame discards any partial sample and sync window, and no sample_valid is produced for that frame.

## Timing
- Latency: sample_valid and the new sample_out are visible in the cycle after the clock edge that samples the last data bit.
- locked rises in the cycle after the edge sampling the last sync bit in HUNT. It falls in the cycle after the edge sampling the last bit of the MISS_LIMIT-th bad sync word, and sync_err pulses in that same cycle.
- Back-to-back frames with bit_en held high give exactly one sample_valid every DATA_W+SYNC_W cycles.
- Gaps in bit_en stretch all timing. No bits are lost or duplicated, and a gap placed on the last-bit cycle delays the strobe until the next enabled bit.
- In HUNT, overlapping matches are detected at bit granularity. There is no word alignment.

## Test plan
- Reset: hold rst for 2 cycles with random bit_in and bit_en=1 -> sample_out=0, sample_valid=0, locked=0, sync_err=0 during reset and on the first cycle after it.
- Acquisition: after reset send 13 random bits containing no 0xA5, then 0xA5, then 0x1234, with bit_en=1 -> locked rises the cycle after the 21st bit; sample_out=0x1234 with sample_valid pulse the cycle after the 37th bit; no earlier sample_valid.
- Gapped input: repeat the acquisition with bit_en=0 on every third cycle, including the last data bit -> the same sample 0x1234, with the strobe one cycle after the enabled last bit; exactly one pulse.
- Flywheel: locked stream of 0xA5/0xBEEF frames where one sync is replaced by 0xA4 -> sync_err pulses once and locked stays 1; the next sample is 0xBEEF, and matches resume with the miss counter reset.
- Loss of lock: three consecutive syncs set to 0x00 -> sync_err pulses 3 times and locked falls with the third. The next 0xA5/0x0F0F pair re-acquires and outputs 0x0F0F.
- Mid-frame reset: assert rst for 1 cycle after 8 data bits of a locked frame -> locked=0, no sample_valid for that frame; a fresh 0xA5/0x5555 then yields sample_out=0x5555.

Source files
------------

// File: rtl/serial_sample_framer_if.sv
// rtl/serial_sample_framer_if.sv - serial bit input and framed sample output bundle
interface serial_sample_framer_if #(
  parameter int DATA_W = 16
);
  logic              bit_in;
  logic              bit_en;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              locked;
  logic              sync_err;

  modport master (
    output bit_in, bit_en,
    input  sample_out, sample_valid, locked, sync_err
  );

  modport slave (
    input  bit_in, bit_en,
    output sample_out, sample_valid, locked, sync_err
  );
endinterface

// File: rtl/serial_sample_framer.sv
// rtl/serial_sample_framer.sv - sync-word hunting flywheel framer assembling MSB-first samples
module serial_sample_framer #(
  parameter int                DATA_W     = 16,
  parameter int                SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int                MISS_LIMIT = 3
) (
  input logic                   clk,
  input logic                   rst,
  serial_sample_framer_if.slave bus
);
  localparam int CW = $clog2(((DATA_W > SYNC_W) ? DATA_W : SYNC_W) + 1);
  localparam int FW = $clog2(SYNC_W + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_W);
  localparam logic [FW-1:0] FILL_MIN  = FW'(SYNC_W - 1);
  localparam logic [3:0]    MISS_MAX  = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  state_t            state;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] data_sr;
  logic [CW-1:0]     bit_cnt;
  logic [FW-1:0]     fill_cnt;
  logic [3:0]        miss_cnt;
  logic [DATA_W-1:0] sample_out_r;
  logic              sample_valid_r;
  logic              locked_r;
  logic              sync_err_r;

  logic [SYNC_W-1:0] sync_next;
  logic [DATA_W-1:0] data_next;
  logic [3:0]        miss_next;

  assign sync_next = {sync_sr[SYNC_W-2:0], bus.bit_in};
  assign data_next = {data_sr[DATA_W-2:0], bus.bit_in};
  assign miss_next = miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      sync_sr        <= '0;
      data_sr        <= '0;
      bit_cnt        <= '0;
      fill_cnt       <= '0;
      miss_cnt       <= '0;
      sample_out_r   <= '0;
      sample_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      sync_err_r     <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      sync_err_r     <= 1'b0;
      if (bus.bit_en) begin
        unique case (state)
          HUNT: begin
            sync_sr <= sync_next;
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + FW'(1);
            // fill guard keeps reset zeros from forming part of a match
            if (sync_next == SYNC_WORD && fill_cnt >= FILL_MIN) begin
              state    <= DATA;
              bit_cnt  <= '0;
              miss_cnt <= '0;
              locked_r <= 1'b1;
            end
          end
          DATA: begin
            data_sr <= data_next;
            if (bit_cnt == DATA_LAST) begin
              sample_out_r   <= data_next;
              sample_valid_r <= 1'b1;
              state          <= CHECK;
              bit_cnt        <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          CHECK: begin
            sync_sr <= sync_next;
            if (bit_cnt == SYNC_LAST) begin
              bit_cnt <= '0;
              if (sync_next == SYNC_WORD) begin
                miss_cnt <= '0;
                state    <= DATA;
              end else begin
                sync_err_r <= 1'b1;
                if (miss_next == MISS_MAX) begin
                  // lost lock: restart hunting from an empty window
                  state    <= HUNT;
                  locked_r <= 1'b0;
                  fill_cnt <= '0;
                  miss_cnt <= '0;
                  sync_sr  <= '0;
                end else begin
                  miss_cnt <= miss_next;
                  state    <= DATA;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.locked       = locked_r;
  assign bus.sync_err     = sync_err_r;
endmodule

// File: tb/tb_serial_sample_framer.sv
// tb/tb_serial_sample_framer.sv - vector-table bench for serial_sample_framer
module tb_serial_sample_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sample_framer_if #(.DATA_W(16)) bus ();

  serial_sample_framer #(
    .DATA_W(16), .SYNC_W(8), .SYNC_WORD(8'hA5), .MISS_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        en;
    logic        b;
    logic        ev;
    logic        el;
    logic        ee;
    logic [15:0] es;
  } vec_t;

  vec_t        tbl[$];
  logic        exp_lock;
  logic [15:0] exp_samp;
  bit          gap_on;
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void add(input logic r, en, b, ev, el, ee, input logic [15:0] es);
    vec_t v;
    v.r = r; v.en = en; v.b = b; v.ev = ev; v.el = el; v.ee = ee; v.es = es;
    tbl.push_back(v);
  endfunction

  function automatic void do_reset(input int n);
    exp_lock = 1'b0;
    exp_samp = 16'h0000;
    for (int i = 0; i < n; i++) add(1'b1, 1'b1, i[0], 1'b0, 1'b0, 1'b0, 16'h0000);
  endfunction

  // word of n bits, MSB first; expectations for the last bit given explicitly
  function automatic void send(input logic [15:0] w, input int n, input logic lock_after,
                               input logic pulse_valid, input logic pulse_err, input bit gap_last);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap_on && ((cyc % 3 == 2) || (i == 0 && gap_last))) begin
        add(1'b0, 1'b0, ~w[i], 1'b0, exp_lock, 1'b0, exp_samp);
        cyc++;
      end
      if (i == 0) begin
        if (pulse_valid) exp_samp = w;
        exp_lock = lock_after;
        add(1'b0, 1'b1, w[i], pulse_valid, exp_lock, pulse_err, exp_samp);
      end else begin
        add(1'b0, 1'b1, w[i], 1'b0, exp_lock, 1'b0, exp_samp);
      end
      cyc++;
    end
  endfunction

  function automatic void chk(input string nm, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endfunction

  task automatic drive(input logic r, input logic en, input logic b);
    @(negedge clk);
    rst        = r;
    bus.bit_en = en;
    bus.bit_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          pulses[$];
    int          errs;
    int          t;
    logic        err_at_fall;
    logic [23:0] frame;

    bus.bit_en = 1'b0;
    bus.bit_in = 1'b0;
    gap_on     = 1'b0;
    cyc        = 0;

    // reset, acquisition, flywheel, loss of lock, re-acquisition
    do_reset(2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    send(16'h1999, 13, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h1234, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'hBEEF, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h00A4, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'hBEEF, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'hBEEF, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h0000, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'hBEEF, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h0000, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'hBEEF, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h0000, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h0F0F, 16, 1'b1, 1'b1, 1'b0, 1'b0);

    // gapped acquisition, gap forced just before the last data bit
    do_reset(1);
    gap_on = 1'b1;
    cyc    = 0;
    send(16'h1999, 13, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h1234, 16, 1'b1, 1'b1, 1'b0, 1'b1);
    gap_on = 1'b0;
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);

    // mid-frame reset after 8 data bits
    do_reset(1);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h0012, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1);
    send(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h5555, 16, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].en, tbl[k].b);
      chk("sample_valid", k, 32'(bus.sample_valid), 32'(tbl[k].ev));
      chk("locked", k, 32'(bus.locked), 32'(tbl[k].el));
      chk("sync_err", k, 32'(bus.sync_err), 32'(tbl[k].ee));
      chk("sample_out", k, 32'(bus.sample_out), 32'(tbl[k].es));
    end

    // back-to-back frames: one strobe every DATA_W+SYNC_W cycles
    frame = {8'hA5, 16'hBEEF};
    t = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 23; i >= 0; i--) begin
        drive(1'b0, 1'b1, frame[i]);
        if (bus.sample_valid) pulses.push_back(t);
        t++;
      end
    end
    chk("b2b_pulse_count", 0, 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("b2b_interval", 1, 32'(pulses[1] - pulses[0]), 32'd24);
      chk("b2b_interval", 2, 32'(pulses[2] - pulses[1]), 32'd24);
    end
    chk("b2b_sample", 3, 32'(bus.sample_out), 32'h0000BEEF);

    // bad syncs until lock drops, bounded by a cycle budget
    frame       = {8'hFF, 16'h0000};
    errs        = 0;
    err_at_fall = 1'b0;
    t           = 0;
    while (bus.locked && t < 200) begin
      drive(1'b0, 1'b1, frame[23 - (t % 24)]);
      if (bus.sync_err) errs++;
      if (!bus.locked) err_at_fall = bus.sync_err;
      t++;
    end
    chk("loss_timeout", t, 32'(bus.locked), 32'd0);
    chk("loss_err_count", t, 32'(errs), 32'd3);
    chk("loss_err_with_fall", t, 32'(err_at_fall), 32'd1);
    chk("loss_cycles", t, 32'(t), 32'd56);
    chk("loss_sample", t, 32'(bus.sample_out), 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
